// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the four-digit seven-segment scan controller:
//   - register offsets decoded from daddr[3:2]
//   - scan state encoding
//   - anode drive table (active-low, one entry per digit)
//   - "display off" constants and the CTRL reset value
// -----------------------------------------------------------------------------
package sseg_pkg;

   // Word offsets of the bus registers (daddr[3:2])
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   // Scan sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // All anodes released / all segments dark (both active-low)
   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Enabled, full brightness
   localparam logic [31:0] CTRL_RESET = 32'h0000_00F1;

   // Anode pattern for digits 0..3
   localparam logic [3:0] ANODE_TABLE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   function automatic logic [3:0] anode_for(input logic [1:0] digit);
      return ANODE_TABLE[digit];
   endfunction

endpackage

// File: rtl/sseg_pwm_timer.sv
// -----------------------------------------------------------------------------
// sseg_pwm_timer
// Prescaler plus 16-step PWM step counter used while a digit is being driven.
// All state changes on the falling clock edge, matching the bus peripheral.
//
// Ports:
//   clk         system clock (falling edge active)
//   rst         asynchronous active-low reset
//   run         count enable; counters are held at 0 while low
//   clear       force both counters back to 0 on this edge
//   step_done   last clock of the current PWM step
//   s[3:0]      current PWM step index 0..15
//   drive_done  last clock of step 15, i.e. end of the digit's drive window
// -----------------------------------------------------------------------------
module sseg_pwm_timer #(
   parameter int STEP_CYCLES = 6510
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       clear,
   output logic       step_done,
   output logic [3:0] s,
   output logic       drive_done
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

   logic [PW-1:0] presc;

   assign step_done  = run && (presc == PRESC_LAST);
   assign drive_done = step_done && (s == 4'hF);

   // Prescaler counts clocks inside a step; the step index advances when the
   // prescaler wraps and itself wraps from 15 back to 0 at the end of drive,
   // so the next digit starts from a clean count without extra logic.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         s     <= 4'd0;
      end else if (clear || !run) begin
         presc <= '0;
         s     <= 4'd0;
      end else if (step_done) begin
         presc <= '0;
         s     <= s + 4'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
// Bus-mapped scan controller for a 4-digit multiplexed seven-segment display.
// Software writes the next frame's four segment bytes into DATA; they are
// copied into the active buffer only at the start of a frame (entering BLANK
// for digit 0) so a frame never mixes old and new bytes. Each digit gets a
// short all-off blanking gap followed by a 16-step PWM drive window whose duty
// is set by CTRL.bright.
//
// Ports:
//   clk           system clock, all state changes on the falling edge
//   rst           asynchronous active-low reset
//   ie, iaddr     instruction-side bus, not used by this peripheral
//   de            data enable
//   daddr         data address, register select = daddr[3:2]
//   drw           drw[0] is the write strobe
//   din           write data
//   iout          instruction read data, always 0
//   dout          combinational register read data
//   sseg_an       digit anodes, active-low
//   sseg_display  segment byte for the digit currently lit
//   frame_tick    one-clock pulse on every frame latch
//
// Registers:
//   0x0 DATA    pending segment bytes, byte n = digit n
//   0x4 CTRL    [0] enable, [7:4] bright
//   0x8 STATUS  [1:0] digit, [2] pending_valid, [31:16] frame_cnt (read-only)
//   0xC         reads 0
// -----------------------------------------------------------------------------
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int STEP_CYCLES  = 6510,
   parameter int BLANK_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ie,
   input  logic        de,
   input  logic [31:0] iaddr,
   input  logic [31:0] daddr,
   input  logic [1:0]  drw,
   input  logic [31:0] din,
   output logic [31:0] iout,
   output logic [31:0] dout,
   output logic [3:0]  sseg_an,
   output logic [7:0]  sseg_display,
   output logic        frame_tick
);

   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

   scan_state_t state;
   scan_state_t next_state;

   logic [31:0]   data_reg;
   logic [31:0]   active;
   logic          pending_valid;
   logic          enable;
   logic [3:0]    bright;
   logic [3:0]    bright_q;
   logic [1:0]    digit;
   logic [BW-1:0] blank_cnt;
   logic [15:0]   frame_cnt;

   logic [1:0] reg_sel;
   logic       wr_en;
   logic       data_wr;
   logic       ctrl_wr;
   logic       next_enable;
   logic       latch;
   logic       step_done;
   logic       drive_done;
   logic [3:0] s;

   logic unused_bits;

   assign unused_bits = ^{ie, iaddr, daddr[31:4], daddr[1:0], drw[1], step_done};

   assign iout    = 32'd0;
   assign reg_sel = daddr[3:2];
   assign wr_en   = de && drw[0];
   assign data_wr = wr_en && (reg_sel == REG_DATA);
   assign ctrl_wr = wr_en && (reg_sel == REG_CTRL);

   // Enable as it will be after this edge; a CTRL write takes effect on the
   // same edge it is issued, both for stopping and for restarting the scan.
   assign next_enable = ctrl_wr ? din[0] : enable;

   sseg_pwm_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (state == ST_DRIVE),
      .clear     (!next_enable),
      .step_done (step_done),
      .s         (s),
      .drive_done(drive_done)
   );

   // Next-state decode. A frame latch happens whenever the sequencer enters
   // BLANK for digit 0: either restarting from IDLE or finishing digit 3.
   // Disabling overrides everything, including a latch due on the same edge.
   always_comb begin
      next_state = state;
      latch      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (next_enable) begin
               next_state = ST_BLANK;
               latch      = 1'b1;
            end
         end
         ST_BLANK: begin
            if (blank_cnt == BLANK_LAST) begin
               next_state = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (drive_done) begin
               next_state = ST_BLANK;
               latch      = (digit == 2'd3);
            end
         end
         default: begin
            next_state = ST_BLANK;
         end
      endcase
      if (!next_enable) begin
         next_state = ST_IDLE;
         latch      = 1'b0;
      end
   end

   // Pin drive: the anode is lit only during DRIVE and only for PWM steps up
   // to the brightness captured at the start of this digit's drive window.
   always_comb begin
      sseg_an      = AN_OFF;
      sseg_display = SEG_OFF;
      if ((state == ST_DRIVE) && (s <= bright_q)) begin
         sseg_an      = anode_for(digit);
         sseg_display = active[{digit, 3'b000} +: 8];
      end
   end

   // Register read mux
   always_comb begin
      dout = 32'd0;
      case (reg_sel)
         REG_DATA:   dout = data_reg;
         REG_CTRL:   dout = {24'd0, bright, 3'd0, enable};
         REG_STATUS: dout = {frame_cnt, 13'd0, pending_valid, digit};
         default:    dout = 32'd0;
      endcase
   end

   // Bus-writable registers. A DATA write on the same edge as a frame latch
   // still leaves pending_valid set, because the latch consumed the old value
   // and the new one is still waiting for the next frame.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         data_reg      <= 32'd0;
         pending_valid <= 1'b0;
         enable        <= CTRL_RESET[0];
         bright        <= CTRL_RESET[7:4];
      end else begin
         if (data_wr) begin
            data_reg <= din;
         end
         if (data_wr) begin
            pending_valid <= 1'b1;
         end else if (latch) begin
            pending_valid <= 1'b0;
         end
         if (ctrl_wr) begin
            enable <= din[0];
            bright <= din[7:4];
         end
      end
   end

   // Frame latch: swap in the pending pattern (if any), count the frame and
   // raise frame_tick for exactly the clock following the latch edge.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         active     <= 32'd0;
         frame_cnt  <= 16'd0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= latch;
         if (latch) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (pending_valid) begin
               active <= data_reg;
            end
         end
      end
   end

   // Sequencer state, digit index, blanking counter and the brightness
   // snapshot. Brightness is sampled only on BLANK->DRIVE so a CTRL write
   // mid-digit cannot change the duty of the digit already being driven.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_BLANK;
         digit     <= 2'd0;
         blank_cnt <= '0;
         bright_q  <= 4'd0;
      end else begin
         state <= next_state;

         if ((state == ST_BLANK) && (next_state == ST_BLANK)) begin
            blank_cnt <= blank_cnt + 1'b1;
         end else begin
            blank_cnt <= '0;
         end

         if (!next_enable) begin
            digit <= 2'd0;
         end else if ((state == ST_DRIVE) && drive_done) begin
            digit <= digit + 2'd1;
         end

         if ((state == ST_BLANK) && (next_state == ST_DRIVE)) begin
            bright_q <= bright;
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
// Self-checking bench for sseg_scan_ctrl with STEP_CYCLES = 2, BLANK_CYCLES = 3.
// The reference model tracks a single "cycles since frame start" count and
// derives digit, blanking and PWM step from it arithmetically.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

   localparam int STEP  = 2;
   localparam int BLANK = 3;
   localparam int P     = BLANK + 16 * STEP;
   localparam int F     = 4 * P;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ie = 1'b0;
   logic        de = 1'b0;
   logic [31:0] iaddr = 32'd0;
   logic [31:0] daddr = 32'd0;
   logic [1:0]  drw = 2'd0;
   logic [31:0] din = 32'd0;
   logic [31:0] iout;
   logic [31:0] dout;
   logic [3:0]  sseg_an;
   logic [7:0]  sseg_display;
   logic        frame_tick;

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state
   bit          m_run;
   int          m_t;
   logic [31:0] m_data;
   logic [31:0] m_active;
   bit          m_pend;
   logic [15:0] m_fcnt;
   bit          m_en;
   logic [3:0]  m_bright;
   logic [3:0]  m_bq;
   bit          m_tick;

   sseg_scan_ctrl #(
      .STEP_CYCLES (STEP),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ie          (ie),
      .de          (de),
      .iaddr       (iaddr),
      .daddr       (daddr),
      .drw         (drw),
      .din         (din),
      .iout        (iout),
      .dout        (dout),
      .sseg_an     (sseg_an),
      .sseg_display(sseg_display),
      .frame_tick  (frame_tick)
   );

   // Free-running clock; the DUT acts on the falling edge
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_run    = 1'b1;
      m_t      = 0;
      m_data   = 32'd0;
      m_active = 32'd0;
      m_pend   = 1'b0;
      m_fcnt   = 16'd0;
      m_en     = 1'b1;
      m_bright = 4'hF;
      m_bq     = 4'h0;
      m_tick   = 1'b0;
   endtask

   // One clock of the reference behaviour, given this edge's bus transaction
   task automatic modelStep(input bit we, input logic [1:0] sel, input logic [31:0] wd);
      bit latch;
      bit newEn;
      latch = 1'b0;
      if (m_run) begin
         m_t++;
         if (m_t == F) begin
            m_t   = 0;
            latch = 1'b1;
         end
         if (m_t % P == BLANK) m_bq = m_bright;
      end
      newEn = (we && sel == 2'd1) ? wd[0] : m_en;
      if (!newEn) begin
         m_run = 1'b0;
         m_t   = 0;
         latch = 1'b0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
         latch = 1'b1;
      end
      if (latch) begin
         if (m_pend) begin
            m_active = m_data;
            m_pend   = 1'b0;
         end
         m_fcnt = m_fcnt + 16'd1;
      end
      m_tick = latch;
      if (we && sel == 2'd0) begin
         m_data = wd;
         m_pend = 1'b1;
      end
      if (we && sel == 2'd1) begin
         m_en     = wd[0];
         m_bright = wd[7:4];
      end
   endtask

   task automatic expDisplay(output logic [3:0] an, output logic [7:0] seg);
      int phase;
      int dig;
      logic [3:0] one;
      one = 4'b0001;
      an  = 4'hF;
      seg = 8'hFF;
      if (m_run) begin
         phase = m_t % P;
         dig   = m_t / P;
         if (phase >= BLANK && (phase - BLANK) / STEP <= int'(m_bq)) begin
            an  = ~(one << dig);
            seg = m_active[8*dig +: 8];
         end
      end
   endtask

   function automatic logic [31:0] expDout(input logic [31:0] a);
      logic [1:0] dig;
      dig = m_run ? 2'(m_t / P) : 2'd0;
      case (a[3:2])
         2'd0:    return m_data;
         2'd1:    return {24'd0, m_bright, 3'd0, m_en};
         2'd2:    return {m_fcnt, 13'd0, m_pend, dig};
         default: return 32'd0;
      endcase
   endfunction

   // Drive one bus cycle (called just after a rising edge), check all outputs
   // against the model, then advance the model across the falling edge.
   task automatic applyStimulus(input logic de_v, input logic [1:0] drw_v,
                                input logic [31:0] addr_v, input logic [31:0] din_v);
      logic [3:0] eAn;
      logic [7:0] eSeg;
      de    = de_v;
      drw   = drw_v;
      daddr = addr_v;
      din   = din_v;
      iaddr = $urandom;
      ie    = 1'($urandom_range(0, 1));
      #1;
      expDisplay(eAn, eSeg);
      checkOutput("sseg_an", {28'd0, sseg_an}, {28'd0, eAn});
      checkOutput("sseg_display", {24'd0, sseg_display}, {24'd0, eSeg});
      checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
      checkOutput("dout", dout, expDout(addr_v));
      checkOutput("iout", iout, 32'd0);
      @(negedge clk);
      if (rst) modelStep(de_v && drw_v[0], addr_v[3:2], din_v);
      else modelReset();
      @(posedge clk);
   endtask

   task automatic writeReg(input logic [1:0] sel, input logic [31:0] value);
      logic [31:0] a;
      a = $urandom;
      a[3:2] = sel;
      applyStimulus(1'b1, {1'($urandom_range(0, 1)), 1'b1}, a, value);
   endtask

   // Idle bus cycles with random reads (no writes)
   task automatic runCycles(input int n);
      logic [31:0] a;
      logic        d;
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         d = 1'($urandom_range(0, 1));
         if (d) applyStimulus(1'b1, {1'($urandom_range(0, 1)), 1'b0}, a, $urandom);
         else   applyStimulus(1'b0, 2'($urandom_range(0, 3)), a, $urandom);
      end
   endtask

   task automatic randomTraffic(input int n);
      int          r;
      logic [31:0] v;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 199);
         v = $urandom;
         if (r < 4) begin
            writeReg(2'd0, v);
         end else if (r == 4) begin
            v[0] = ($urandom_range(0, 3) != 0);
            writeReg(2'd1, v);
         end else if (r == 5) begin
            writeReg(2'($urandom_range(2, 3)), v);
         end else begin
            runCycles(1);
         end
      end
   endtask

   // Sample STATUS at the current rising edge and compare a field to a constant
   task automatic checkStatus(input string tag, input logic [31:0] mask, input logic [31:0] exp);
      de  = 1'b1;
      drw = 2'b00;
      daddr = 32'h8;
      #1;
      checkOutput(tag, dout & mask, exp);
   endtask

   initial begin
      bit found;
      modelReset();
      @(posedge clk);

      // Reset state
      applyStimulus(1'b1, 2'b00, 32'h8, 32'd0);
      applyStimulus(1'b1, 2'b00, 32'h4, 32'd0);
      checkStatus("reset_status", 32'hFFFF_FFFF, 32'd0);
      rst = 1'b1;

      // Pattern load and full-brightness scanning over two frames
      $display("[TB] basic scan");
      writeReg(2'd0, 32'h4433_2211);
      runCycles(2 * F);

      // Minimum brightness
      $display("[TB] brightness 0");
      writeReg(2'd1, 32'h0000_0001);
      runCycles(F + P);
      writeReg(2'd1, 32'h0000_00F1);

      // Mid-frame update stays pending until the frame latch
      $display("[TB] mid-frame update");
      runCycles(50);
      writeReg(2'd0, 32'hAABB_CCDD);
      checkStatus("pending_set", 32'h4, 32'h4);
      runCycles(F);
      checkStatus("pending_clear", 32'h4, 32'h0);

      // DATA write on the very edge of a frame latch
      $display("[TB] write on latch edge");
      writeReg(2'd0, 32'h1234_5678);
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         if (m_run && m_t == F - 1) found = 1'b1;
         else runCycles(1);
      end
      checkOutput("wait_latch_edge", {31'd0, found}, 32'd1);
      writeReg(2'd0, 32'h9ABC_DEF0);
      checkStatus("pending_after_same_edge", 32'h4, 32'h4);
      runCycles(P);

      // Disable during DRIVE of digit 2, then restart
      $display("[TB] disable and restart");
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         if (m_run && m_t / P == 2 && m_t % P >= BLANK + 4) found = 1'b1;
         else runCycles(1);
      end
      checkOutput("wait_digit2", {31'd0, found}, 32'd1);
      writeReg(2'd1, 32'h0000_0000);
      checkStatus("idle_digit", 32'h3, 32'h0);
      runCycles(5);
      writeReg(2'd1, 32'h0000_00F1);
      runCycles(P + 5);

      // Asynchronous reset between clock edges during DRIVE
      $display("[TB] async reset");
      found = 1'b0;
      for (int i = 0; i < 2 * F && !found; i++) begin
         if (m_run && m_t % P >= BLANK + 2) found = 1'b1;
         else runCycles(1);
      end
      checkOutput("wait_drive", {31'd0, found}, 32'd1);
      de    = 1'b1;
      drw   = 2'b00;
      daddr = 32'h8;
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_an", {28'd0, sseg_an}, 32'hF);
      checkOutput("rst_display", {24'd0, sseg_display}, 32'hFF);
      checkOutput("rst_status", dout, 32'd0);
      modelReset();
      @(negedge clk);
      @(posedge clk);
      rst = 1'b1;
      runCycles(10);

      // frame_cnt wrap, starting near the top of its range
      $display("[TB] frame counter wrap");
      writeReg(2'd1, 32'h0000_0000);
      force dut.frame_cnt = 16'hFFFE;
      #1 release dut.frame_cnt;
      m_fcnt = 16'hFFFE;
      writeReg(2'd1, 32'h0000_00F1);
      applyStimulus(1'b1, 2'b00, 32'h8, 32'd0);
      writeReg(2'd1, 32'h0000_0000);
      writeReg(2'd1, 32'h0000_00F1);
      checkStatus("fcnt_wrap", 32'hFFFF_0000, 32'h0);
      runCycles(10);

      // Randomized bus traffic against the model
      $display("[TB] random traffic");
      randomTraffic(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Bus-mapped scan controller for the 4-digit seven-segment display.
- Holds double-buffered digit patterns. Sequences the anodes with a blanking gap between digits to stop ghosting.
- Applies per-digit PWM brightness. Swaps in new patterns only at frame boundaries, so the display never tears.
- Sits on the data bus as a peripheral and directly drives the board's sseg_an and sseg_display pins.

Parameters:
- STEP_CYCLES, 6510, clocks per PWM step (25 MHz / (60 Hz × 4 digits × 16 steps)).
- BLANK_CYCLES, 32, clocks with all anodes off at each digit change.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, per the bus convention.
- rst  in  1  reset, asynchronous, active-low.
- ie  in  1  instruction enable; unused.
- de  in  1  data enable.
- iaddr  in  32  unused.
- daddr  in  32  data address; register select is daddr[3:2].
- drw  in  2  drw[0] = write strobe.
- din  in  32  write data.
- iout  out  32  constant 0.
- dout  out  32  combinational read data.
- sseg_an  out  4  anodes, active-low.
- sseg_display  out  8  segment byte for the active digit.
- frame_tick  out  1  one-clock pulse at each frame latch.

Behaviour:
- Registers (write when de && drw[0]):
  - 0x0 DATA: pending patterns, byte n = digit n.
  - 0x4 CTRL: bit0 = enable, bits[7:4] = bright; all other bits read 0.
  - 0x8 STATUS: read-only. [1:0] = current digit, [2] = pending_valid, [31:16] = frame_cnt. Writes are ignored.
  - 0xC: reads 0.
- Reset values:
  - DATA = 0, active = 0, pending_valid = 0.
  - CTRL = 0x000000F1 (enabled, full brightness).
  - frame_cnt = 0, digit = 0.
  - sseg_an = 4'b1111, sseg_display = 8'hFF, frame_tick = 0.
  - State = BLANK, digit 0, counters 0.
- State machine:
  - IDLE: enable = 0. sseg_an = 1111, sseg_display = FF, counters held at 0. When enable = 1 → BLANK with digit = 0 and a frame latch performed.
  - BLANK: sseg_an = 1111, sseg_display = FF for BLANK_CYCLES clocks → DRIVE. The bright value is sampled into bright_q on this transition.
  - DRIVE: lasts 16 × STEP_CYCLES clocks. The step index s (0..15) advances every STEP_CYCLES clocks.
    - Anode for the current digit is asserted (digit 0 = 1110, 1 = 1101, 2 = 1011, 3 = 0111) while s <= bright_q; otherwise 1111.
    - sseg_display = active byte of the current digit when the anode is asserted; otherwise FF.
    - At the end of DRIVE: digit increments mod 4, then → BLANK.
- Frame latch, performed on entering BLANK for digit 0:
  - If pending_valid: active ← DATA, pending_valid ← 0.
  - frame_cnt increments, wrapping at 16 bits.
  - frame_tick = 1 for that clock.
- Simultaneous DATA write and latch on the same edge: the latch uses the pre-edge DATA. The new value is stored and pending_valid ends at 1 (set wins).
- CTRL write with enable = 0, at any state: → IDLE on that edge; digit and counters reset to 0.
- CTRL bright change mid-DRIVE: no effect until the next BLANK→DRIVE transition.
- Digit timing:
  - Digit period = BLANK_CYCLES + 16 × STEP_CYCLES clocks.
  - Frame = 4 digit periods.
  - First anode assertion occurs BLANK_CYCLES clocks after enable or reset release.
- Reset assertion mid-operation: all state returns to reset values immediately, without waiting for a clock.

Decomposition:
- Shared package sseg_pkg holds:
  - register offsets (REG_DATA = 0, REG_CTRL = 1, REG_STATUS = 2);
  - state encodings (IDLE, BLANK, DRIVE);
  - the anode pattern table;
  - SEG_OFF = 8'hFF and the CTRL reset constant.
- One sub-module, sseg_pwm_timer: the prescaler and step counter, with outputs step_done, s[3:0] and drive_done.

Test Plan:
All scenarios use STEP_CYCLES = 2 and BLANK_CYCLES = 3, giving a digit period of 35 clocks.
1. Reset release, DATA written with 0x44332211 → after the first latch, digit 0 shows 11 on anode 1110 from clock 3 for 32 clocks; then 3 blank clocks; then 22 on anode 1101.
2. CTRL = 0x01 (bright 0) → the anode is asserted for only 2 of the 32 DRIVE clocks per digit; sseg_display = FF for the rest.
3. Write DATA 0xAABBCCDD mid-frame → STATUS[2] = 1; the display keeps showing the old bytes until the frame_tick pulse, then shows DD/CC/BB/AA; STATUS[2] = 0 after the latch.
4. DATA write on the same edge as the latch → the previous pending value becomes active, the new value remains pending, and STATUS[2] = 1.
5. CTRL = 0x00 during DRIVE of digit 2 → next edge gives sseg_an = 1111 and STATUS[1:0] = 0. Rewriting 0xF1 → 3 blank clocks, then digit 0 with frame_cnt incremented by 1.
6. Assert reset during DRIVE between clock edges → sseg_an = 1111, sseg_display = FF, dout @0x8 = 0 immediately; frame_cnt wraps from 0xFFFF to 0 on a forced long run.
